dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 64-word data memory between two requesters: port 0 is the core load/store path, port 1 is the program/data loader or debug master.
- Accepts one request at a time and arbitrates round-robin when both ports request.
- Sequences the memory access, waits out a configurable read latency, and returns a registered response to the winner.
- Sits between the datapath/loader and the data memory at the top level.

Parameters:
- AW, 32, address width in bits (byte address).
- DW, 32, data width in bits.
- RD_LATENCY, 0, cycles from mem_en (read) to valid mem_rdata; legal range 0..3; 0 means a combinational-read memory.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  request valid
- m0_we, m1_we  in  1  1=write, 0=read
- m0_addr, m1_addr  in  AW  byte address
- m0_wdata, m1_wdata  in  DW  write data
- m0_gnt, m1_gnt  out  1  request accepted this cycle
- m0_rvalid, m1_rvalid  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DW  read data, valid with rvalid
- m0_err, m1_err  out  1  misaligned access flag, valid with rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  word-aligned byte address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- One clock domain (clk). reset is synchronous and active-high.
- Reset effects: state=IDLE, last_winner=1, all rvalid/err/rdata=0, mem_en/mem_we/mem_addr/mem_wdata=0, busy=0.
- Reset mid-transaction drops the transaction: no rvalid, no further mem_en.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any req is high, the winner's gnt is asserted combinationally in the same cycle.
  - At that edge: capture we/addr/wdata and the winner index, update last_winner, go to ACCESS.
  - gnt is never asserted outside IDLE.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port != last_winner wins.
- Requester handshake: the requester holds req/we/addr/wdata stable until gnt. Deasserting req before gnt is legal and withdraws the request.
- ACCESS (exactly one cycle, call it T), aligned address (addr[1:0]==0):
  - mem_en=1, mem_we=captured we, mem_addr=captured addr, mem_wdata=captured wdata.
  - Write: go to RESP.
  - Read with RD_LATENCY=0: sample mem_rdata at the end of T, go to RESP.
  - Read with RD_LATENCY>0: go to WAIT with counter=RD_LATENCY.
- ACCESS, misaligned address: mem_en stays 0, err flag is set, go to RESP.
- WAIT:
  - Counter decrements each cycle.
  - mem_rdata is sampled at the end of cycle T+RD_LATENCY; then go to RESP.
  - mem_en=0 throughout WAIT.
- RESP (one cycle):
  - Winner's rvalid=1.
  - rdata = sampled value for reads, 0 for writes and errors.
  - err=1 only for misaligned accesses.
  - Next state is IDLE.
  - Non-winner rvalid stays 0.
- Latency: gnt in cycle 0, mem_en in cycle 1, rvalid in cycle 2+RD_LATENCY for reads, cycle 2 for writes and errors.
- Back-to-back: the next grant is possible in cycle 3+RD_LATENCY (reads), i.e. the first IDLE cycle after RESP.
- Outputs outside their active state are 0. rdata/err are registered and cleared when rvalid is low.
- Address arithmetic: no translation. mem_addr passes the full AW bits; the memory indexes [AW-1:2].

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both request; last_winner is neither used nor updated.
- Undefined: round-robin as above.

Decomposition:
- Package dmem_arb_pkg holds:
  - enum arb_state_e {IDLE, ACCESS, WAIT, RESP};
  - constants PORT_CORE=0, PORT_LOADER=1, RD_LATENCY_MAX=3;
  - a struct arb_req_t {we, addr, wdata} for the captured request.
- One sub-module, rr_arb2:
  - combinational two-way winner select from req and last_winner;
  - holds the last_winner register, updated on an accept strobe;
  - implements the DMEM_ARB_FIXED_PRIO_EN override.

Test Plan:
1. RD_LATENCY=0; m0 writes 0xDEADBEEF to 0x10, then m0 reads 0x10. Required: m0_gnt cycle 0; mem_en=1/mem_we=1/mem_addr=0x10 cycle 1; m0_rvalid cycle 2 with rdata=0; read returns m0_rdata=0xDEADBEEF with rvalid in cycle 2 of the read.
2. RD_LATENCY=2; m1 reads 0x20 with the memory model driving 0x12345678 in cycle T+2. Required: m1_rvalid in cycle 4 after gnt with m1_rdata=0x12345678, and mem_en high only in cycle 1.
3. After reset, m0_req and m1_req held high continuously for 4 transactions. Required: grant order m0, m1, m0, m1. With DMEM_ARB_FIXED_PRIO_EN defined: m0, m0, m0, m0.
4. m0 read at address 0x13. Required: no mem_en; m0_rvalid in cycle 2 with m0_err=1 and m0_rdata=0.
5. reset asserted in the WAIT cycle of an m1 read with RD_LATENCY=3. Required: next cycle state IDLE, busy=0, no m1_rvalid; the next simultaneous request grants m0 (last_winner=1).
6. m1 raises req during m0's ACCESS cycle. Required: m1_gnt stays 0 until the IDLE cycle after m0's RESP, then m1_gnt=1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_e : arbiter FSM states
//   arb_req_t   : request captured at grant time (we, addr, wdata)
//   PORT_*      : requester indices used as bit positions in grant vectors
//   word_aligned: true when a byte address points at a 32-bit word boundary
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  // Requester indices; also the bit positions in the two-bit req/gnt vectors.
  localparam int PORT_CORE   = 0;
  localparam int PORT_LOADER = 1;

  // Deepest memory read pipeline the wait counter can cover.
  localparam int RD_LATENCY_MAX = 3;
  localparam int CNT_W          = $clog2(RD_LATENCY_MAX + 1);

  // Widths of the captured request. The arbiter's AW/DW parameters must
  // match these values.
  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;

  typedef struct packed {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } arb_req_t;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way request arbiter with a last-winner register.
// Latency: combinational grant; last winner updates on the accept edge.
// Backpressure: grants nothing while en_i is low; requesters simply hold req.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset (last winner -> loader)
//   en_i         : arbitration allowed this cycle
//   req_i[1:0]   : request vector, bit index = port number
//   accept_i     : a grant is being taken this cycle
//   gnt_o[1:0]   : one-hot (or zero) grant vector
//
// Build option DMEM_ARB_FIXED_PRIO_EN: when defined the core port always wins
// a tie and the last-winner register is held at its reset value.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // 1 = loader won most recently, so the core has priority on the next tie.
  logic last_winner_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01: gnt_o = 2'b01;
        2'b10: gnt_o = 2'b10;
        2'b11: begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
          gnt_o = 2'b01;
`else
          // Tie: the port that did not win last time goes first.
          gnt_o = last_winner_q ? 2'b01 : 2'b10;
`endif
        end
        default: gnt_o = 2'b00;
      endcase
    end
  end

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_accept;
  assign unused_accept = accept_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= 1'b1;
    end else if (accept_i) begin
      last_winner_q <= gnt_o[PORT_LOADER];
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core (m0) and loader (m1).
// Latency: gnt cycle 0, mem_en cycle 1, rvalid cycle 2 (+RD_LATENCY on reads).
// Backpressure: one transaction in flight; gnt held low until the FSM is IDLE.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   mX_req/we/addr/wdata    : requester X command, held stable until mX_gnt
//   mX_gnt                  : request accepted this cycle (combinational, IDLE only)
//   mX_rvalid/rdata/err     : one-cycle completion; rdata/err are 0 when rvalid is 0
//   mem_en/we/addr/wdata    : memory strobe and command, active only in ACCESS
//   mem_rdata               : memory read data, RD_LATENCY cycles after mem_en
//   busy                    : FSM is not IDLE
//
// Parameters: AW/DW must equal DMEM_AW/DMEM_DW in dmem_arb_pkg; RD_LATENCY 0..3.
// Build option DMEM_ARB_FIXED_PRIO_EN selects fixed core priority on ties
// (default: round-robin).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 0
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LATENCY);

  arb_state_e       state_q;
  arb_req_t         req_q;
  arb_req_t         req_d;
  logic             win_q;        // 1 = loader owns the current transaction
  logic [CNT_W-1:0] cnt_q;        // read cycles still to wait, counts down to 1
  logic             mem_en_q;

  logic             m0_rvalid_q, m1_rvalid_q;
  logic [DW-1:0]    m0_rdata_q,  m1_rdata_q;
  logic             m0_err_q,    m1_err_q;

  logic [1:0]       arb_gnt;
  logic             accept;

  // Response generated on the transition into RESP.
  logic             resp_fire;
  logic             resp_err;
  logic [DW-1:0]    resp_data;

  // ---------------------------------------------------------------------
  // Arbitration: only enabled in IDLE, so no grant can leak into a busy cycle.
  // ---------------------------------------------------------------------
  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q == IDLE),
    .req_i    ({m1_req, m0_req}),
    .accept_i (accept),
    .gnt_o    (arb_gnt)
  );

  assign accept = |arb_gnt;
  assign m0_gnt = arb_gnt[PORT_CORE];
  assign m1_gnt = arb_gnt[PORT_LOADER];

  // Winner's command, captured at the accept edge.
  always_comb begin
    req_d = '0;
    if (arb_gnt[PORT_LOADER]) begin
      req_d.we    = m1_we;
      req_d.addr  = DMEM_AW'(m1_addr);
      req_d.wdata = DMEM_DW'(m1_wdata);
    end else begin
      req_d.we    = m0_we;
      req_d.addr  = DMEM_AW'(m0_addr);
      req_d.wdata = DMEM_DW'(m0_wdata);
    end
  end

  // ---------------------------------------------------------------------
  // Completion decode. A misaligned access completes straight out of ACCESS
  // without touching memory; a read samples mem_rdata in the cycle the
  // memory presents it (ACCESS for a combinational memory, last WAIT cycle
  // otherwise).
  // ---------------------------------------------------------------------
  always_comb begin
    resp_fire = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    case (state_q)
      ACCESS: begin
        if (!word_aligned(req_q.addr[1:0])) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else if (req_q.we) begin
          resp_fire = 1'b1;
        end else if (RD_LATENCY == 0) begin
          resp_fire = 1'b1;
          resp_data = mem_rdata;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          resp_fire = 1'b1;
          resp_data = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM with registered outputs. Pulse outputs default to 0 every cycle and
  // are only raised on the edge that enters the state they belong to.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      win_q       <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
    end else begin
      mem_en_q    <= 1'b0;
      m0_rvalid_q <= resp_fire & ~win_q;
      m1_rvalid_q <= resp_fire &  win_q;
      m0_rdata_q  <= (resp_fire & ~win_q) ? resp_data : '0;
      m1_rdata_q  <= (resp_fire &  win_q) ? resp_data : '0;
      m0_err_q    <= resp_fire & ~win_q & resp_err;
      m1_err_q    <= resp_fire &  win_q & resp_err;

      case (state_q)
        IDLE: begin
          if (accept) begin
            req_q    <= req_d;
            win_q    <= arb_gnt[PORT_LOADER];
            // Misaligned requests never strobe the memory.
            mem_en_q <= word_aligned(req_d.addr[1:0]);
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (resp_fire) begin
            state_q <= RESP;
          end else begin
            cnt_q   <= LAT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (resp_fire) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory command is held in req_q and only exposed while mem_en_q is set,
  // so the bus reads as zero outside the ACCESS cycle.
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_en_q & req_q.we;
  assign mem_addr  = mem_en_q ? req_q.addr[AW-1:0]  : '0;
  assign mem_wdata = mem_en_q ? req_q.wdata[DW-1:0] : '0;

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;

  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances with RD_LATENCY 0, 2 and 3, each
// with its own word memory model. Stimulus pushes expected responses into a
// scoreboard; a negedge monitor pops and compares on every rvalid.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic        rst       [3];
  logic        m0_req    [3];
  logic        m1_req    [3];
  logic        m0_we     [3];
  logic        m1_we     [3];
  logic [31:0] m0_addr   [3];
  logic [31:0] m1_addr   [3];
  logic [31:0] m0_wdata  [3];
  logic [31:0] m1_wdata  [3];
  logic        m0_gnt    [3];
  logic        m1_gnt    [3];
  logic        m0_rvalid [3];
  logic        m1_rvalid [3];
  logic [31:0] m0_rdata  [3];
  logic [31:0] m1_rdata  [3];
  logic        m0_err    [3];
  logic        m1_err    [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic        busy      [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L  = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    localparam int LI = (L == 0) ? 0 : L - 1;

    logic [31:0] mem [64];
    logic [5:0]  ap  [4];
    logic        av  [4];
    logic [31:0] rd;

    dmem_arbiter #(.AW(32), .DW(32), .RD_LATENCY(L)) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .m0_req    (m0_req[g]),
      .m0_we     (m0_we[g]),
      .m0_addr   (m0_addr[g]),
      .m0_wdata  (m0_wdata[g]),
      .m0_gnt    (m0_gnt[g]),
      .m0_rvalid (m0_rvalid[g]),
      .m0_rdata  (m0_rdata[g]),
      .m0_err    (m0_err[g]),
      .m1_req    (m1_req[g]),
      .m1_we     (m1_we[g]),
      .m1_addr   (m1_addr[g]),
      .m1_wdata  (m1_wdata[g]),
      .m1_gnt    (m1_gnt[g]),
      .m1_rvalid (m1_rvalid[g]),
      .m1_rdata  (m1_rdata[g]),
      .m1_err    (m1_err[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (rd),
      .busy      (busy[g])
    );

    // Memory initialised to 0xC0DE0000 | word index; read data appears L
    // cycles after mem_en and is garbage in every other cycle.
    always_ff @(posedge clk) begin
      if (rst[g]) begin
        for (int k = 0; k < 64; k++) mem[k] <= 32'hC0DE_0000 | 32'(k);
        for (int s = 0; s < 4; s++) begin
          av[s] <= 1'b0;
          ap[s] <= 6'd0;
        end
      end else begin
        if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:2]] <= mem_wdata[g];
        av[0] <= mem_en[g] && !mem_we[g];
        ap[0] <= mem_addr[g][7:2];
        for (int s = 1; s < 4; s++) begin
          av[s] <= av[s-1];
          ap[s] <= ap[s-1];
        end
      end
    end

    always_comb begin
      rd = 32'hBAD0_0000 ^ 32'(cyc);
      if (L == 0) begin
        if (mem_en[g] && !mem_we[g]) rd = mem[mem_addr[g][7:2]];
      end else begin
        if (av[LI]) rd = mem[ap[LI]];
      end
    end
  end

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction

  function automatic logic gnt_of(input int i, input int p);
    return (p == 0) ? m0_gnt[i] : m1_gnt[i];
  endfunction

  task automatic set_req(input int i, input int p, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      m0_req[i] = v; m0_we[i] = we; m0_addr[i] = a; m0_wdata[i] = d;
    end else begin
      m1_req[i] = v; m1_we[i] = we; m1_addr[i] = a; m1_wdata[i] = d;
    end
  endtask

  task automatic push_exp(input int i, input int p, input logic we, input logic [31:0] a,
                          input logic [31:0] rdv, input logic err, input int g);
    exp_t e;
    e.inst  = i;
    e.port  = p;
    e.rdata = rdv;
    e.err   = err;
    e.due   = g + 2 + ((!we && a[1:0] == 2'b00) ? lat_of(i) : 0);
    sb.push_back(e);
  endtask

  // Waits for the grant of an already-raised request, optionally records the
  // expected response, then drops req. Returns at posedge+1 of cycle g+1.
  task automatic wait_gnt(input int i, input int p, input logic we, input logic [31:0] a,
                          input logic [31:0] rdv, input logic err, input bit push,
                          output int g);
    bit got;
    got = 1'b0;
    g   = -1;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (gnt_of(i, p)) begin
        got = 1'b1;
        g   = cyc;
        if (push) push_exp(i, p, we, a, rdv, err, g);
      end
      @(posedge clk); #1;
    end
    set_req(i, p, 1'b0, 1'b0, 32'h0, 32'h0);
    chk1("gnt_seen", got, 1'b1);
  endtask

  // Both ports request reads continuously until n grants have been issued.
  task automatic run_both(input int i, input int n, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] r0, input logic [31:0] r1);
    int k, last_g, p, ep;
    k = 0;
    last_g = 0;
    set_req(i, 0, 1'b1, 1'b0, a0, 32'h0);
    set_req(i, 1, 1'b1, 1'b0, a1, 32'h0);
    for (int c = 0; c < 80 && k < n; c++) begin
      @(negedge clk);
      if (m0_gnt[i] || m1_gnt[i]) begin
        p = m1_gnt[i] ? 1 : 0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        ep = 0;
`else
        ep = k % 2;
`endif
        chk1("gnt_onehot", m0_gnt[i] & m1_gnt[i], 1'b0);
        chk32("grant_order", p, ep);
        if (k > 0) chk32("grant_spacing", cyc - last_g, 3 + lat_of(i));
        push_exp(i, p, 1'b0, (p == 1) ? a1 : a0, (p == 1) ? r1 : r0, 1'b0, cyc);
        last_g = cyc;
        k++;
      end
      @(posedge clk); #1;
    end
    set_req(i, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(i, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk32("grants_done", k, n);
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
    chk32("sb_drained", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m0_rvalid[i] || m1_rvalid[i]) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rvalid: inst %0d m0_rvalid=%b m1_rvalid=%b, required no response (cycle %0d)",
                   i, m0_rvalid[i], m1_rvalid[i], cyc);
        end else begin
          mon_e = sb.pop_front();
          chk32("rsp_inst", i, mon_e.inst);
          chk1("rsp_single", m0_rvalid[i] & m1_rvalid[i], 1'b0);
          chk32("rsp_port", m1_rvalid[i] ? 1 : 0, mon_e.port);
          chk32("rsp_cycle", cyc, mon_e.due);
          if (m1_rvalid[i]) begin
            chk32("rsp_rdata", m1_rdata[i], mon_e.rdata);
            chk1("rsp_err", m1_err[i], mon_e.err);
            chk32("rsp_other_rdata", m0_rdata[i], 32'h0);
          end else begin
            chk32("rsp_rdata", m0_rdata[i], mon_e.rdata);
            chk1("rsp_err", m0_err[i], mon_e.err);
            chk32("rsp_other_rdata", m1_rdata[i], 32'h0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: still running at %0t, required to finish", $time);
    $fatal(1);
  end

  initial begin
    int g, g2;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      set_req(i, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(i, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk1("rst_busy", busy[i], 1'b0);
      chk1("rst_mem_en", mem_en[i], 1'b0);
    end
    chk1("rst_mem_we", mem_we[0], 1'b0);
    chk32("rst_mem_addr", mem_addr[0], 32'h0);
    chk32("rst_mem_wdata", mem_wdata[0], 32'h0);
    chk1("rst_m0_rvalid", m0_rvalid[0], 1'b0);
    chk1("rst_m1_rvalid", m1_rvalid[0], 1'b0);
    chk32("rst_m0_rdata", m0_rdata[0], 32'h0);
    chk1("rst_m1_err", m1_err[0], 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(posedge clk); #1;

    // Both ports held high: alternating grants every 3 cycles (RD_LATENCY=0).
    run_both(0, 4, 32'h40, 32'h44, 32'hC0DE_0010, 32'hC0DE_0011);
    drain();

    // m0 write then read, RD_LATENCY=0.
    set_req(0, 0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    wait_gnt(0, 0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, g);
    @(negedge clk);
    chk1("t1w_mem_en", mem_en[0], 1'b1);
    chk1("t1w_mem_we", mem_we[0], 1'b1);
    chk32("t1w_mem_addr", mem_addr[0], 32'h10);
    chk32("t1w_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    chk1("t1w_busy", busy[0], 1'b1);
    chk1("t1w_no_gnt", m0_gnt[0], 1'b0);
    drain();
    set_req(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_gnt(0, 0, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, g);
    @(negedge clk);
    chk1("t1r_mem_en", mem_en[0], 1'b1);
    chk1("t1r_mem_we", mem_we[0], 1'b0);
    drain();

    // Misaligned read: no memory strobe, err response in cycle 2.
    set_req(0, 0, 1'b1, 1'b0, 32'h13, 32'h0);
    wait_gnt(0, 0, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, g);
    @(negedge clk);
    chk1("t4_mem_en_access", mem_en[0], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("t4_mem_en_resp", mem_en[0], 1'b0);
    drain();

    // m1 raises req during m0's ACCESS: granted in the IDLE cycle after RESP.
    set_req(0, 0, 1'b1, 1'b0, 32'h40, 32'h0);
    wait_gnt(0, 0, 1'b0, 32'h40, 32'hC0DE_0010, 1'b0, 1'b1, g);
    set_req(0, 1, 1'b1, 1'b0, 32'h44, 32'h0);
    wait_gnt(0, 1, 1'b0, 32'h44, 32'hC0DE_0011, 1'b0, 1'b1, g2);
    chk32("t6_m1_gnt_cycle", g2, g + 3);
    drain();

    // RD_LATENCY=2: m1 writes 0x12345678 at 0x20, then reads it back.
    set_req(1, 1, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    wait_gnt(1, 1, 1'b1, 32'h20, 32'h0, 1'b0, 1'b1, g);
    drain();
    set_req(1, 1, 1'b1, 1'b0, 32'h20, 32'h0);
    wait_gnt(1, 1, 1'b0, 32'h20, 32'h1234_5678, 1'b0, 1'b1, g);
    @(negedge clk);
    chk1("t2_mem_en_access", mem_en[1], 1'b1);
    chk32("t2_mem_addr", mem_addr[1], 32'h20);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk1("t2_mem_en_low", mem_en[1], 1'b0);
    end
    drain();

    // RD_LATENCY=3: reset during WAIT drops the m1 read.
    set_req(2, 1, 1'b1, 1'b0, 32'h24, 32'h0);
    wait_gnt(2, 1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, g);
    @(negedge clk);
    chk1("t5_mem_en_access", mem_en[2], 1'b1);
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(negedge clk);
    chk1("t5_busy_wait", busy[2], 1'b1);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    @(negedge clk);
    chk1("t5_busy_after_rst", busy[2], 1'b0);
    chk1("t5_no_rvalid", m1_rvalid[2], 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk1("t5_no_mem_en", mem_en[2], 1'b0);
    end
    @(posedge clk); #1;
    run_both(2, 2, 32'h28, 32'h2C, 32'hC0DE_000A, 32'hC0DE_000B);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
